// File: rtl/csi2_pkg.sv
// Shared constants and types for the CSI-2 capture controller: short-packet data types
// and the capture state encoding.
package csi2_pkg;

  localparam logic [5:0] DtFs = 6'h00;
  localparam logic [5:0] DtFe = 6'h01;
  localparam logic [5:0] DtLs = 6'h02;
  localparam logic [5:0] DtLe = 6'h03;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StFrame,
    StLine,
    StDone
  } capture_state_e;

endpackage

// File: rtl/csi2_capture_if.sv
// Packet-in / memory-write-out bundle of the capture controller. The master side is the
// CSI-2 packet source; the slave side is the capture controller itself.
interface csi2_capture_if #(
  parameter int unsigned ADDR_WIDTH = 20
) ();

  logic                  short_valid;
  logic [1:0]            short_vc;
  logic [5:0]            short_data_type;
  logic [15:0]           short_data;
  logic                  pixel_valid;
  logic [1:0]            pixel_vc;
  logic [31:0]           pixel_word;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [31:0]           write_data;

  modport master (
    output short_valid, short_vc, short_data_type, short_data,
    output pixel_valid, pixel_vc, pixel_word,
    input  write_enable, write_address, write_data
  );

  modport slave (
    input  short_valid, short_vc, short_data_type, short_data,
    input  pixel_valid, pixel_vc, pixel_word,
    output write_enable, write_address, write_data
  );

endinterface

// File: rtl/csi2_watchdog.sv
// Inactivity watchdog: counts enabled cycles since the last clear and flags expiry once
// LIMIT quiet cycles have elapsed. A cycle that clears never reports expiry.
module csi2_watchdog #(
  parameter logic [23:0] LIMIT = 24'd1000000
) (
  input  logic clock_p,
  input  logic reset_n,
  input  logic clear,
  input  logic count_enable,
  output logic expired
);

  logic [23:0] count_q;

  always_ff @(posedge clock_p or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_enable && count_q != 24'hFF_FFFF) begin
      count_q <= count_q + 24'd1;
    end
  end

  // Expiry in the cycle holding LIMIT-1 lets the consumer leave exactly LIMIT edges later.
  assign expired = count_enable && !clear && (count_q >= LIMIT - 24'd1);

endmodule

// File: rtl/csi2_capture_controller.sv
// Single-frame CSI-2 capture: arms on capture_start, writes one virtual channel's line
// payload to memory and reports frame status. Watchdog built only with CSI2_CAPTURE_TIMEOUT_EN.
module csi2_capture_controller
  import csi2_pkg::*;
#(
  parameter logic [1:0]  VC             = 2'd0,
  parameter logic [15:0] EXPECTED_LINES = 16'd480,
  parameter logic [19:0] MAX_WORDS      = 20'd153600,
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic                  clock_p,
  input  logic                  reset_n,
  input  logic                  capture_start,
  input  logic                  capture_abort,
  input  logic [ADDR_WIDTH-1:0] base_address,
  csi2_capture_if.slave         bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_number,
  output logic [15:0]           line_count,
  output logic                  error_lines,
  output logic                  error_overflow,
  output logic                  error_timeout
);

  localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

  capture_state_e        state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [19:0]           word_count_q;
  logic [15:0]           line_count_q;
  logic [15:0]           frame_number_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [31:0]           wr_data_q;
  logic                  frame_done_q;
  logic                  err_lines_q;
  logic                  err_overflow_q;
  logic                  err_timeout_q;

  logic short_hit;
  logic pixel_hit;
  logic fs_hit;
  logic fe_hit;
  logic ls_hit;
  logic le_hit;
  logic timeout_hit;

  assign short_hit = bus.short_valid && (bus.short_vc == VC);
  assign pixel_hit = bus.pixel_valid && (bus.pixel_vc == VC);
  assign fs_hit    = short_hit && (bus.short_data_type == DtFs);
  assign fe_hit    = short_hit && (bus.short_data_type == DtFe);
  assign ls_hit    = short_hit && (bus.short_data_type == DtLs);
  assign le_hit    = short_hit && (bus.short_data_type == DtLe);

`ifdef CSI2_CAPTURE_TIMEOUT_EN
  logic wd_clear;
  logic wd_count_enable;

  assign wd_clear = short_hit || pixel_hit || (state_q == StIdle && capture_start);
  assign wd_count_enable = (state_q == StArmed) || (state_q == StFrame) || (state_q == StLine);

  csi2_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock_p      (clock_p),
    .reset_n      (reset_n),
    .clear        (wd_clear),
    .count_enable (wd_count_enable),
    .expired      (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock_p or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      ptr_q          <= '0;
      word_count_q   <= '0;
      line_count_q   <= '0;
      frame_number_q <= '0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      frame_done_q   <= 1'b0;
      err_lines_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      // Abort beats everything; a write registered last cycle is already on the outputs.
      if (capture_abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (capture_start) begin
              state_q        <= StArmed;
              ptr_q          <= base_address;
              word_count_q   <= '0;
              line_count_q   <= '0;
              err_lines_q    <= 1'b0;
              err_overflow_q <= 1'b0;
              err_timeout_q  <= 1'b0;
            end
          end
          StArmed: begin
            if (timeout_hit) begin
              state_q       <= StDone;
              frame_done_q  <= 1'b1;
              err_timeout_q <= 1'b1;
            end else if (fs_hit) begin
              state_q        <= StFrame;
              frame_number_q <= bus.short_data;
            end
          end
          StFrame, StLine: begin
            if (timeout_hit) begin
              state_q       <= StDone;
              frame_done_q  <= 1'b1;
              err_timeout_q <= 1'b1;
            end else if (fe_hit) begin
              state_q      <= StDone;
              frame_done_q <= 1'b1;
              err_lines_q  <= (line_count_q != EXPECTED_LINES);
            end else if (ls_hit) begin
              state_q <= StLine;
              if (line_count_q != 16'hFFFF) begin
                line_count_q <= line_count_q + 16'd1;
              end
            end else if (le_hit) begin
              state_q <= StFrame;
            end
            if (state_q == StLine && pixel_hit) begin
              if (word_count_q < MAX_WORDS) begin
                wr_en_q      <= 1'b1;
                wr_addr_q    <= ptr_q;
                wr_data_q    <= bus.pixel_word;
                ptr_q        <= ptr_q + AddrOne;
                word_count_q <= word_count_q + 20'd1;
              end else begin
                err_overflow_q <= 1'b1;
              end
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign busy              = (state_q != StIdle);
  assign frame_done        = frame_done_q;
  assign frame_number      = frame_number_q;
  assign line_count        = line_count_q;
  assign error_lines       = err_lines_q;
  assign error_overflow    = err_overflow_q;
  assign error_timeout     = err_timeout_q;
  assign bus.write_enable  = wr_en_q;
  assign bus.write_address = wr_addr_q;
  assign bus.write_data    = wr_data_q;

endmodule

// File: tb/tb_csi2_capture_controller.sv
// Directed bench: two controllers (unlimited and MAX_WORDS=5) share one packet stream;
// frame flow, line errors, overflow, address wrap, abort, reset and watchdog are checked.
module tb_csi2_capture_controller;
  import csi2_pkg::*;

  localparam int unsigned AW = 20;

  logic          clk;
  logic          rst_n;
  logic          capture_start;
  logic          capture_abort;
  logic [AW-1:0] base_address;
  logic          short_valid;
  logic [1:0]    short_vc;
  logic [5:0]    short_data_type;
  logic [15:0]   short_data;
  logic          pixel_valid;
  logic [1:0]    pixel_vc;
  logic [31:0]   pixel_word;

  logic        busy_a, done_a, err_lines_a, err_ovf_a, err_to_a;
  logic [15:0] fnum_a, lines_a;
  logic        busy_b, done_b, err_lines_b, err_ovf_b, err_to_b;
  logic [15:0] fnum_b, lines_b;

  csi2_capture_if #(.ADDR_WIDTH(AW)) bus_a ();
  csi2_capture_if #(.ADDR_WIDTH(AW)) bus_b ();

  assign bus_a.short_valid     = short_valid;
  assign bus_a.short_vc        = short_vc;
  assign bus_a.short_data_type = short_data_type;
  assign bus_a.short_data      = short_data;
  assign bus_a.pixel_valid     = pixel_valid;
  assign bus_a.pixel_vc        = pixel_vc;
  assign bus_a.pixel_word      = pixel_word;
  assign bus_b.short_valid     = short_valid;
  assign bus_b.short_vc        = short_vc;
  assign bus_b.short_data_type = short_data_type;
  assign bus_b.short_data      = short_data;
  assign bus_b.pixel_valid     = pixel_valid;
  assign bus_b.pixel_vc        = pixel_vc;
  assign bus_b.pixel_word      = pixel_word;

  csi2_capture_controller #(
    .VC(2'd0), .EXPECTED_LINES(16'd4), .MAX_WORDS(20'd153600), .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(24'd100)
  ) dut_a (
    .clock_p(clk), .reset_n(rst_n), .capture_start(capture_start),
    .capture_abort(capture_abort), .base_address(base_address), .bus(bus_a),
    .busy(busy_a), .frame_done(done_a), .frame_number(fnum_a), .line_count(lines_a),
    .error_lines(err_lines_a), .error_overflow(err_ovf_a), .error_timeout(err_to_a)
  );

  csi2_capture_controller #(
    .VC(2'd0), .EXPECTED_LINES(16'd4), .MAX_WORDS(20'd5), .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(24'd100)
  ) dut_b (
    .clock_p(clk), .reset_n(rst_n), .capture_start(capture_start),
    .capture_abort(capture_abort), .base_address(base_address), .bus(bus_b),
    .busy(busy_b), .frame_done(done_b), .frame_number(fnum_b), .line_count(lines_b),
    .error_lines(err_lines_b), .error_overflow(err_ovf_b), .error_timeout(err_to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write and frame_done logs, only ever appended to by the monitor.
  logic [AW-1:0] addr_a[$];
  logic [31:0]   data_a[$];
  logic [AW-1:0] addr_b[$];
  int            ndone_a = 0;
  int            ndone_b = 0;

  always @(negedge clk) begin
    if (bus_a.write_enable === 1'b1) begin
      addr_a.push_back(bus_a.write_address);
      data_a.push_back(bus_a.write_data);
    end
    if (bus_b.write_enable === 1'b1) addr_b.push_back(bus_b.write_address);
    if (done_a === 1'b1) ndone_a++;
    if (done_b === 1'b1) ndone_b++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_short(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] d);
    short_vc = vc; short_data_type = dt; short_data = d; short_valid = 1'b1;
    @(negedge clk);
    short_valid = 1'b0;
  endtask

  task automatic send_pixel(input logic [1:0] vc, input logic [31:0] w);
    pixel_vc = vc; pixel_word = w; pixel_valid = 1'b1;
    @(negedge clk);
    pixel_valid = 1'b0;
  endtask

  task automatic begin_capture(input logic [AW-1:0] base);
    base_address = base; capture_start = 1'b1;
    @(negedge clk);
    capture_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int ia, ib, da, db, hit;

  initial begin
    rst_n = 1'b1; capture_start = 1'b0; capture_abort = 1'b0; base_address = '0;
    short_valid = 1'b0; short_vc = '0; short_data_type = '0; short_data = '0;
    pixel_valid = 1'b0; pixel_vc = '0; pixel_word = '0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_we", bus_a.write_enable, 0);
    check("rst_done", done_a, 0);
    check("rst_lines", lines_a, 0);
    check("rst_fnum", fnum_a, 0);
    check("rst_errs", {err_lines_a, err_ovf_a, err_to_a}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Nominal frame: 4 lines x 2 words, with noise that must be ignored.
    ia = addr_a.size(); ib = addr_b.size(); da = ndone_a; db = ndone_b;
    begin_capture(20'h00100);
    check("armed_busy", busy_a, 1);
    send_pixel(2'd0, 32'hDEAD_0000);
    send_short(2'd0, DtFe, 16'd0);
    send_short(2'd0, DtLs, 16'd0);
    send_short(2'd1, DtFs, 16'd3);
    send_short(2'd0, DtFs, 16'd7);
    check("pre_fs_lines", lines_a, 0);
    for (int i = 0; i < 4; i++) begin
      send_short(2'd0, DtLs, 16'd0);
      send_pixel(2'd0, 32'hA000_0000 + 2 * i);
      send_pixel(2'd1, 32'hBAD0_0000);
      send_pixel(2'd0, 32'hA000_0000 + 2 * i + 1);
      send_short(2'd0, DtLe, 16'd0);
      send_pixel(2'd0, 32'hBAD1_0000);
      if (i == 1) begin_capture(20'h00555);
    end
    base_address = 20'h00100;
    short_vc = 2'd0; short_data_type = DtFe; short_valid = 1'b1;
    @(negedge clk);
    short_valid = 1'b0;
    check("done_pulse", done_a, 1);
    capture_start = 1'b1;
    @(negedge clk);
    capture_start = 1'b0;
    check("start_in_done", busy_a, 0);
    idle(2);
    check("n1_writes", addr_a.size() - ia, 8);
    for (int i = 0; i < 8; i++) begin
      if (ia + i < addr_a.size()) begin
        check($sformatf("n1_addr%0d", i), addr_a[ia + i], 32'h100 + i);
        check($sformatf("n1_data%0d", i), data_a[ia + i], 32'hA000_0000 + i);
      end
    end
    check("n1_fnum", fnum_a, 7);
    check("n1_lines", lines_a, 4);
    check("n1_done_cnt", ndone_a - da, 1);
    check("n1_errs", {err_lines_a, err_ovf_a, err_to_a}, 0);
    check("ovf_writes", addr_b.size() - ib, 5);
    if (addr_b.size() > ib + 4) check("ovf_last_addr", addr_b[ib + 4], 32'h104);
    check("ovf_flag", err_ovf_b, 1);
    check("ovf_lines_ok", err_lines_b, 0);
    check("ovf_done_cnt", ndone_b - db, 1);

    // Three lines (one closed by implicit LE, one with a reserved short) -> line error.
    ia = addr_a.size(); da = ndone_a;
    begin_capture(20'h00200);
    send_short(2'd0, DtFs, 16'd9);
    send_short(2'd0, DtLs, 16'd0);
    send_pixel(2'd0, 32'h1);
    send_pixel(2'd0, 32'h2);
    send_short(2'd0, DtLs, 16'd0);
    send_pixel(2'd0, 32'h3);
    send_short(2'd0, 6'h05, 16'd0);
    send_pixel(2'd0, 32'h4);
    send_short(2'd0, DtLe, 16'd0);
    send_short(2'd0, DtLs, 16'd0);
    send_pixel(2'd0, 32'h5);
    send_pixel(2'd0, 32'h6);
    send_short(2'd0, DtLe, 16'd0);
    send_short(2'd0, DtFe, 16'd0);
    idle(2);
    check("l3_writes", addr_a.size() - ia, 6);
    if (addr_a.size() > ia + 5) begin
      check("l3_addr5", addr_a[ia + 5], 32'h205);
      check("l3_data3", data_a[ia + 3], 32'h4);
    end
    check("l3_err_lines", err_lines_a, 1);
    check("l3_ovf_cleared", err_ovf_a, 0);
    check("l3_lines", lines_a, 3);
    check("l3_fnum", fnum_a, 9);
    check("l3_done_cnt", ndone_a - da, 1);

    // Address wrap at the top of the address space.
    ia = addr_a.size();
    begin_capture(20'hFFFFE);
    send_short(2'd0, DtFs, 16'd1);
    for (int i = 0; i < 4; i++) begin
      send_short(2'd0, DtLs, 16'd0);
      if (i < 2) begin
        send_pixel(2'd0, 32'hC0 + 2 * i);
        send_pixel(2'd0, 32'hC0 + 2 * i + 1);
      end
      send_short(2'd0, DtLe, 16'd0);
    end
    send_short(2'd0, DtFe, 16'd0);
    idle(2);
    check("wrap_writes", addr_a.size() - ia, 4);
    if (addr_a.size() > ia + 3) begin
      check("wrap_a0", addr_a[ia], 32'hFFFFE);
      check("wrap_a1", addr_a[ia + 1], 32'hFFFFF);
      check("wrap_a2", addr_a[ia + 2], 32'h0);
      check("wrap_a3", addr_a[ia + 3], 32'h1);
    end
    check("wrap_err_lines", err_lines_a, 0);

    // Abort together with FE and a pixel: abort wins, earlier write still lands.
    ia = addr_a.size(); da = ndone_a;
    begin_capture(20'h00300);
    send_short(2'd0, DtFs, 16'd2);
    send_short(2'd0, DtLs, 16'd0);
    send_pixel(2'd0, 32'h77);
    short_vc = 2'd0; short_data_type = DtFe; short_valid = 1'b1;
    pixel_vc = 2'd0; pixel_word = 32'h88; pixel_valid = 1'b1; capture_abort = 1'b1;
    @(negedge clk);
    short_valid = 1'b0; pixel_valid = 1'b0; capture_abort = 1'b0;
    check("abort_busy", busy_a, 0);
    idle(3);
    check("abort_writes", addr_a.size() - ia, 1);
    check("abort_no_done", ndone_a - da, 0);
    check("abort_err_lines", err_lines_a, 0);

    // Asynchronous reset mid-line, while a write is on the outputs.
    begin_capture(20'h00400);
    send_short(2'd0, DtFs, 16'd5);
    send_short(2'd0, DtLs, 16'd0);
    pixel_vc = 2'd0; pixel_word = 32'h99; pixel_valid = 1'b1;
    @(posedge clk);
    #2;
    pixel_valid = 1'b0;
    check("pre_rst_we", bus_a.write_enable, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_we", bus_a.write_enable, 0);
    check("mid_rst_wa", bus_a.write_address, 0);
    check("mid_rst_wd", bus_a.write_data, 0);
    check("mid_rst_lines", lines_a, 0);
    check("mid_rst_fnum", fnum_a, 0);
    check("mid_rst_done", done_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Watchdog: FS then silence.
    da = ndone_a;
    begin_capture(20'h0);
    send_short(2'd0, DtFs, 16'h11);
`ifdef CSI2_CAPTURE_TIMEOUT_EN
    hit = 0;
    for (int c = 1; c <= 150; c++) begin
      @(posedge clk);
      #1;
      if (done_a === 1'b1 && hit == 0) hit = c;
    end
    check("to_cycles", hit, 100);
    check("to_flag", err_to_a, 1);
    check("to_busy", busy_a, 0);
    check("to_done_cnt", ndone_a - da, 1);
`else
    hit = 0;
    idle(150);
    check("no_to_flag", err_to_a, 0);
    check("no_to_busy", busy_a, 1);
    check("no_to_done", ndone_a - da, 0);
    capture_abort = 1'b1;
    @(negedge clk);
    capture_abort = 1'b0;
    check("no_to_abort", busy_a, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
